node_phase_ctrl: RTL and testbench
==================================

// Module: node_phase_ctrl
// PURPOSE
//  Per-node protocol sequencer in front of myNodeInfo. Accepts parsed packets from the RX parser
//  (valid/ready), forwards the legal ones as a one-cycle en_MNI/fPktType strobe, and walks the
//  setup phases: heartbeat -> CH announce -> timeslot assignment. Then runs the TDMA frame counter
//  that raises tx_req in the node's own slot, and closes the round after FRAMES_PER_ROUND frames.
// PARAMETERS
//  SLOT_W           16    width of pkt_slot / my_slot / slot_cnt
//  NUM_SLOTS        16    slots per TDMA frame (>=2)
//  FRAMES_PER_ROUND 4     frames before round_done
//  SETUP_TIMEOUT    1024  cycles allowed in CH_WAIT or SLOT_WAIT before abort
// PORTS
//  clk        in   1       clock
//  nrst       in   1       reset, synchronous, active-low
//  pkt_valid  in   1       parsed packet present
//  pkt_ready  out  1       controller can consume this cycle
//  pkt_type   in   3       000 HB, 001 CH announce, 100 timeslot, 101 data, others ignored
//  pkt_slot   in   SLOT_W  assigned slot carried by type-100 packets
//  slot_tick  in   1       one-cycle pulse marking slot boundary (from timebase)
//  role       in   1       myNodeInfo role (1 = cluster head)
//  low_E      in   1       myNodeInfo low-energy flag
//  en_MNI     out  1       update strobe to myNodeInfo
//  fPktType   out  3       packet type to myNodeInfo; 3'b111 whenever en_MNI=0
//  tx_req     out  1       one-cycle transmit grant in own slot
//  lowE_skip  out  1       one-cycle pulse: own slot reached but suppressed by low_E
//  round_done out  1       one-cycle pulse at end of round
//  setup_fail out  1       one-cycle pulse on timeout / illegal slot
//  state      out  3       current FSM state (debug)
// BEHAVIOUR
//  Reset: state=IDLE; pkt_ready=0 during reset, en_MNI=0, fPktType=111, tx_req=lowE_skip=
//   round_done=setup_fail=0, slot_cnt=frame_cnt=my_slot=timer=0.
//  Handshake: packet accepted when pkt_valid&pkt_ready. pkt_ready=1 in all states except the
//   cycle en_MNI=1 and state ROLE (max one packet per 2 cycles). Accepted packets not legal for
//   the current state are dropped silently (no strobe).
//  Forwarding: forwarded packet -> en_MNI=1, fPktType=pkt_type registered, exactly 1 cycle after
//   accept, for 1 cycle. fPktType must idle at 111 because myNodeInfo's HB lock decodes it
//   without en_MNI.
//  FSM:
//   IDLE      HB accepted -> forward, timer=0, ->CH_WAIT. All else dropped.
//   CH_WAIT   HB dropped (lock). 001 -> forward, ->ROLE. timer==SETUP_TIMEOUT-1 -> setup_fail, ->IDLE.
//   ROLE      waits 2 cycles (role registers after strobe), then samples role:
//             1 -> my_slot=0, ->TDMA; 0 -> timer=0, ->SLOT_WAIT.
//   SLOT_WAIT 100 with pkt_slot<NUM_SLOTS -> forward, my_slot=pkt_slot, ->TDMA.
//             pkt_slot>=NUM_SLOTS -> drop, setup_fail, ->IDLE. Timeout as CH_WAIT.
//   TDMA      slot_cnt=0, frame_cnt=0 on entry. On slot_tick: slot_cnt+1, wrap NUM_SLOTS-1->0.
//             frame_cnt+1 on wrap. Cycle after tick with new slot_cnt==my_slot:
//             tx_req=1 if low_E=0 else lowE_skip=1. 101 -> forward. HB/001/100 dropped.
//             Wrap that makes frame_cnt==FRAMES_PER_ROUND -> round_done, ->IDLE (no tx for slot 0).
//  Simultaneous: accepted packet beats timeout in the same cycle. slot_tick and data packet in the
//   same cycle are both processed. nrst low mid-operation -> immediate return to reset values.
//  Widths: timer is clog2(SETUP_TIMEOUT) bits, frame_cnt is clog2(FRAMES_PER_ROUND+1) bits.
//   Slot compare is unsigned, full SLOT_W.
// STRUCTURE
//  Package node_pkg: PKT_HB/PKT_CH/PKT_SLOT/PKT_DATA/PKT_NONE(3'b111) constants, FSM state
//   encodings (IDLE=0, CH_WAIT=1, ROLE=2, SLOT_WAIT=3, TDMA=4).
//  Sub-module tdma_slot_counter: slot_cnt/frame_cnt, wrap, own-slot match, round_end.
//   The FSM, handshake and forward register stay in the top module.
// TESTING
//  1 HB, then CH(001), role=0, slot pkt_slot=3 -> three en_MNI pulses (000, 001, 100), each 1 cycle
//    after accept. state ends at TDMA. Third slot_tick -> tx_req=1 one cycle later.
//  2 Two HBs back-to-back in IDLE -> only first forwarded; second dropped in CH_WAIT, fPktType=111.
//  3 CH_WAIT with no packet for 1024 cycles -> setup_fail pulse on cycle 1024, state=IDLE.
//  4 pkt_slot=16 (NUM_SLOTS=16) -> no strobe, setup_fail=1, IDLE. role=1 path -> tx_req in slot 0.
//  5 TDMA with low_E=1 at slot 3 -> lowE_skip=1, tx_req=0. 64 ticks -> round_done, IDLE.
//  6 nrst=0 mid-TDMA with slot_tick high -> next cycle all outputs at reset values, fPktType=111.

Source files
------------

// File: rtl/node_pkg.sv
// Shared definitions for the node protocol sequencer: packet type codes and FSM state encodings.
package node_pkg;

    localparam logic [2:0] PKT_HB   = 3'b000;
    localparam logic [2:0] PKT_CH   = 3'b001;
    localparam logic [2:0] PKT_SLOT = 3'b100;
    localparam logic [2:0] PKT_DATA = 3'b101;
    localparam logic [2:0] PKT_NONE = 3'b111;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CH_WAIT   = 3'd1,
        ROLE      = 3'd2,
        SLOT_WAIT = 3'd3,
        TDMA      = 3'd4
    } state_e;

endpackage

// File: rtl/node_phase_ctrl_if.sv
// Parsed-packet handshake between the RX parser (master) and the phase controller (slave).
interface node_phase_ctrl_if #(
    parameter int unsigned SLOT_W = 16
);

    logic              pkt_valid;
    logic              pkt_ready;
    logic [2:0]        pkt_type;
    logic [SLOT_W-1:0] pkt_slot;

    modport master (output pkt_valid, output pkt_type, output pkt_slot, input pkt_ready);
    modport slave  (input pkt_valid, input pkt_type, input pkt_slot, output pkt_ready);

endinterface

// File: rtl/tdma_slot_counter.sv
// TDMA slot/frame counter: advances on slot ticks while running, flags the own slot one cycle
// after the tick that reaches it, and reports the wrap that completes the round.
module tdma_slot_counter #(
    parameter int unsigned SLOT_W           = 16,
    parameter int unsigned NUM_SLOTS        = 16,
    parameter int unsigned FRAMES_PER_ROUND = 4,
    localparam int unsigned FRAME_W         = $clog2(FRAMES_PER_ROUND + 1)
) (
    input  logic              clk,
    input  logic              nrst,
    input  logic              run,
    input  logic              tick,
    input  logic              low_E,
    input  logic [SLOT_W-1:0] my_slot,
    output logic              tx_req,
    output logic              lowE_skip,
    output logic              round_end
);

    logic [SLOT_W-1:0]  slot_q, slot_d, slot_inc;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               tx_q, tx_d, skip_q, skip_d;
    logic               wrap, own;

    assign wrap      = run && tick && (slot_q == SLOT_W'(NUM_SLOTS - 1));
    assign round_end = wrap && (frame_q == FRAME_W'(FRAMES_PER_ROUND - 1));
    assign slot_inc  = wrap ? '0 : slot_q + 1'b1;
    assign own       = (slot_inc == my_slot);

    always_comb begin
        slot_d  = slot_q;
        frame_d = frame_q;
        tx_d    = 1'b0;
        skip_d  = 1'b0;
        // Held at zero outside TDMA so every entry starts from slot 0, frame 0
        if (!run || round_end) begin
            slot_d  = '0;
            frame_d = '0;
        end else if (tick) begin
            slot_d = slot_inc;
            if (wrap) begin
                frame_d = frame_q + 1'b1;
            end
            tx_d   = own && !low_E;
            skip_d = own && low_E;
        end
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            slot_q  <= '0;
            frame_q <= '0;
            tx_q    <= 1'b0;
            skip_q  <= 1'b0;
        end else begin
            slot_q  <= slot_d;
            frame_q <= frame_d;
            tx_q    <= tx_d;
            skip_q  <= skip_d;
        end
    end

    assign tx_req    = tx_q;
    assign lowE_skip = skip_q;

endmodule

// File: rtl/node_phase_ctrl.sv
// Per-node protocol sequencer: filters parsed packets per setup phase, forwards legal ones to
// myNodeInfo as a one-cycle strobe, then runs the TDMA round.
module node_phase_ctrl
    import node_pkg::*;
#(
    parameter int unsigned SLOT_W           = 16,
    parameter int unsigned NUM_SLOTS        = 16,
    parameter int unsigned FRAMES_PER_ROUND = 4,
    parameter int unsigned SETUP_TIMEOUT    = 1024
) (
    input  logic             clk,
    input  logic             nrst,
    node_phase_ctrl_if.slave pkt,
    input  logic             slot_tick,
    input  logic             role,
    input  logic             low_E,
    output logic             en_MNI,
    output logic [2:0]       fPktType,
    output logic             tx_req,
    output logic             lowE_skip,
    output logic             round_done,
    output logic             setup_fail,
    output logic [2:0]       state
);

    localparam int unsigned TIMER_W = $clog2(SETUP_TIMEOUT);

    state_e             state_q, state_d;
    logic [TIMER_W-1:0] timer_q, timer_d;
    logic [SLOT_W-1:0]  my_slot_q, my_slot_d;
    logic               fwd_q, fwd_d;
    logic [2:0]         type_q, type_d;
    logic               done_q, done_d, fail_q, fail_d;
    logic               ready, accept, timeout, round_end;

    // Ready drops while myNodeInfo digests the CH strobe, so packets come at most every 2 cycles
    assign ready         = nrst && !(fwd_q && (state_q == ROLE));
    assign pkt.pkt_ready = ready;
    assign accept        = pkt.pkt_valid && ready;
    assign timeout       = (timer_q == TIMER_W'(SETUP_TIMEOUT - 1));

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        my_slot_d = my_slot_q;
        fwd_d     = 1'b0;
        type_d    = PKT_NONE;
        done_d    = 1'b0;
        fail_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept && (pkt.pkt_type == PKT_HB)) begin
                    fwd_d   = 1'b1;
                    type_d  = PKT_HB;
                    timer_d = '0;
                    state_d = CH_WAIT;
                end
            end
            CH_WAIT: begin
                if (accept && (pkt.pkt_type == PKT_CH)) begin
                    fwd_d   = 1'b1;
                    type_d  = PKT_CH;
                    timer_d = '0;
                    state_d = ROLE;
                end else if (timeout) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ROLE: begin
                // Timer bit 0 counts the two cycles myNodeInfo needs to register the role
                if (timer_q[0]) begin
                    if (role) begin
                        my_slot_d = '0;
                        state_d   = TDMA;
                    end else begin
                        timer_d = '0;
                        state_d = SLOT_WAIT;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            SLOT_WAIT: begin
                if (accept && (pkt.pkt_type == PKT_SLOT)) begin
                    if (pkt.pkt_slot < SLOT_W'(NUM_SLOTS)) begin
                        fwd_d     = 1'b1;
                        type_d    = PKT_SLOT;
                        my_slot_d = pkt.pkt_slot;
                        state_d   = TDMA;
                    end else begin
                        fail_d  = 1'b1;
                        state_d = IDLE;
                    end
                end else if (timeout) begin
                    fail_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            TDMA: begin
                if (accept && (pkt.pkt_type == PKT_DATA)) begin
                    fwd_d  = 1'b1;
                    type_d = PKT_DATA;
                end
                if (round_end) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            my_slot_q <= '0;
            fwd_q     <= 1'b0;
            type_q    <= PKT_NONE;
            done_q    <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            my_slot_q <= my_slot_d;
            fwd_q     <= fwd_d;
            type_q    <= type_d;
            done_q    <= done_d;
            fail_q    <= fail_d;
        end
    end

    tdma_slot_counter #(
        .SLOT_W          (SLOT_W),
        .NUM_SLOTS       (NUM_SLOTS),
        .FRAMES_PER_ROUND(FRAMES_PER_ROUND)
    ) u_slot_counter (
        .clk      (clk),
        .nrst     (nrst),
        .run      (state_q == TDMA),
        .tick     (slot_tick),
        .low_E    (low_E),
        .my_slot  (my_slot_q),
        .tx_req   (tx_req),
        .lowE_skip(lowE_skip),
        .round_end(round_end)
    );

    assign en_MNI     = fwd_q;
    assign fPktType   = type_q;
    assign round_done = done_q;
    assign setup_fail = fail_q;
    assign state      = state_q;

endmodule

// File: tb/tb_node_phase_ctrl.sv
// Bench for node_phase_ctrl: table-driven setup-phase vectors, a forward-strobe scoreboard and
// hand-written timeout, TDMA round and reset sequences.
module tb_node_phase_ctrl;

    localparam int unsigned SLOT_W   = 16;
    localparam int unsigned N_SLOTS  = 16;
    localparam int unsigned N_FRAMES = 4;
    localparam int unsigned TIMEOUT  = 1024;

    localparam logic [2:0] T_HB = 3'b000, T_CH = 3'b001, T_SLOT = 3'b100;
    localparam logic [2:0] T_DATA = 3'b101, T_NONE = 3'b111;
    localparam logic [2:0] S_IDLE = 3'd0, S_CH = 3'd1, S_ROLE = 3'd2, S_SLOT = 3'd3, S_TDMA = 3'd4;

    logic       clk = 1'b0;
    logic       nrst = 1'b0;
    logic       slot_tick = 1'b0;
    logic       role = 1'b0;
    logic       low_E = 1'b0;
    logic       en_MNI, tx_req, lowE_skip, round_done, setup_fail;
    logic [2:0] fPktType, state;
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    node_phase_ctrl_if #(.SLOT_W(SLOT_W)) pkt_if ();

    node_phase_ctrl #(
        .SLOT_W          (SLOT_W),
        .NUM_SLOTS       (N_SLOTS),
        .FRAMES_PER_ROUND(N_FRAMES),
        .SETUP_TIMEOUT   (TIMEOUT)
    ) dut (
        .clk       (clk),
        .nrst      (nrst),
        .pkt       (pkt_if),
        .slot_tick (slot_tick),
        .role      (role),
        .low_E     (low_E),
        .en_MNI    (en_MNI),
        .fPktType  (fPktType),
        .tx_req    (tx_req),
        .lowE_skip (lowE_skip),
        .round_done(round_done),
        .setup_fail(setup_fail),
        .state     (state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] ptype;
        int         due;
    } exp_t;
    exp_t sb[$];

    typedef struct {
        bit          rst;
        bit          valid;
        logic [2:0]  ptype;
        logic [15:0] slot;
        bit          role;
        bit          exp_ready;
        logic [2:0]  exp_state;
        bit          fwd;
        bit          exp_fail;
    } vec_t;
    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Strobe monitor: each forwarded packet must appear exactly one cycle after its accept
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check("en_MNI strobe", 32'(en_MNI), 1);
            check("fPktType fwd", 32'(fPktType), 32'(e.ptype));
        end else if (en_MNI !== 1'b0) begin
            check("en_MNI unexpected", 32'(en_MNI), 0);
        end else begin
            check("fPktType idle", 32'(fPktType), 32'(T_NONE));
        end
    end

    task automatic add(input bit r, input bit v, input logic [2:0] t, input logic [15:0] s,
                       input bit rl, input bit rdy, input logic [2:0] st, input bit f,
                       input bit fl);
        vecs.push_back('{rst: r, valid: v, ptype: t, slot: s, role: rl, exp_ready: rdy,
                         exp_state: st, fwd: f, exp_fail: fl});
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send(input logic [2:0] t, input logic [15:0] s, input bit fwd);
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_type  = t;
        pkt_if.pkt_slot  = s;
        if (fwd) sb.push_back('{ptype: t, due: cyc + 1});
        @(negedge clk);
        pkt_if.pkt_valid = 1'b0;
    endtask

    task automatic to_tdma(input bit r, input logic [15:0] s);
        nrst = 1'b0;
        step(2);
        nrst = 1'b1;
        role = r;
        send(T_HB, 16'd0, 1'b1);
        send(T_CH, 16'd0, 1'b1);
        step(2);
        if (!r) send(T_SLOT, s, 1'b1);
        check("state TDMA after setup", 32'(state), 32'(S_TDMA));
    endtask

    // Reference slot/frame model starting from TDMA entry
    task automatic run_ticks(input int n, input int my_slot, input int lowe_n, input int data_at);
        int slot, frame;
        bit own, rd, le;
        slot  = 0;
        frame = 0;
        for (int k = 0; k < n; k++) begin
            le        = (k < lowe_n);
            low_E     = le;
            slot_tick = 1'b1;
            if (k == data_at) begin
                pkt_if.pkt_valid = 1'b1;
                pkt_if.pkt_type  = T_DATA;
                sb.push_back('{ptype: T_DATA, due: cyc + 1});
            end
            slot = (slot + 1) % N_SLOTS;
            if (slot == 0) frame++;
            rd  = (frame == N_FRAMES);
            own = (slot == my_slot) && !rd;
            @(negedge clk);
            slot_tick        = 1'b0;
            pkt_if.pkt_valid = 1'b0;
            check($sformatf("tx_req tick %0d", k), 32'(tx_req), 32'(own && !le));
            check($sformatf("lowE_skip tick %0d", k), 32'(lowE_skip), 32'(own && le));
            check($sformatf("round_done tick %0d", k), 32'(round_done), 32'(rd));
            @(negedge clk);
            check($sformatf("pulses cleared tick %0d", k),
                  32'({tx_req, lowE_skip, round_done}), 0);
        end
        low_E = 1'b0;
        check("state after ticks", 32'(state), 32'((frame == N_FRAMES) ? S_IDLE : S_TDMA));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        pkt_if.pkt_valid = 1'b0;
        pkt_if.pkt_type  = T_NONE;
        pkt_if.pkt_slot  = '0;
        @(negedge clk);
        check("reset state", 32'(state), 32'(S_IDLE));
        check("reset fPktType", 32'(fPktType), 32'(T_NONE));
        check("reset pulses", 32'({en_MNI, tx_req, lowE_skip, round_done, setup_fail}), 0);
        check("reset pkt_ready", 32'(pkt_if.pkt_ready), 0);

        //  rst valid type    slot  role rdy state   fwd fail
        add(1, 0, T_NONE, 16'd0,  0, 0, S_IDLE, 0, 0);
        add(0, 1, T_HB,   16'd0,  0, 1, S_CH,   1, 0);
        add(0, 1, T_HB,   16'd0,  0, 1, S_CH,   0, 0);
        add(0, 1, T_DATA, 16'd0,  0, 1, S_CH,   0, 0);
        add(0, 1, T_CH,   16'd0,  0, 1, S_ROLE, 1, 0);
        add(0, 0, T_NONE, 16'd0,  0, 0, S_ROLE, 0, 0);
        add(0, 0, T_NONE, 16'd0,  0, 1, S_SLOT, 0, 0);
        add(0, 1, T_DATA, 16'd0,  0, 1, S_SLOT, 0, 0);
        add(0, 1, T_SLOT, 16'd16, 0, 1, S_IDLE, 0, 1);
        add(0, 1, T_SLOT, 16'd2,  0, 1, S_IDLE, 0, 0);
        add(0, 1, T_HB,   16'd0,  1, 1, S_CH,   1, 0);
        add(0, 1, T_CH,   16'd0,  1, 1, S_ROLE, 1, 0);
        add(0, 0, T_NONE, 16'd0,  1, 0, S_ROLE, 0, 0);
        add(0, 0, T_NONE, 16'd0,  1, 1, S_TDMA, 0, 0);
        add(0, 1, T_DATA, 16'd0,  1, 1, S_TDMA, 1, 0);
        add(0, 1, T_HB,   16'd0,  1, 1, S_TDMA, 0, 0);
        add(1, 0, T_NONE, 16'd0,  0, 0, S_IDLE, 0, 0);
        add(0, 1, T_HB,   16'd0,  0, 1, S_CH,   1, 0);
        add(0, 1, T_CH,   16'd0,  0, 1, S_ROLE, 1, 0);
        add(0, 0, T_NONE, 16'd0,  0, 0, S_ROLE, 0, 0);
        add(0, 0, T_NONE, 16'd0,  0, 1, S_SLOT, 0, 0);
        add(0, 1, T_SLOT, 16'd15, 0, 1, S_TDMA, 1, 0);
        add(1, 0, T_NONE, 16'd0,  0, 0, S_IDLE, 0, 0);

        for (int i = 0; i < vecs.size(); i++) begin
            nrst             = !vecs[i].rst;
            role             = vecs[i].role;
            pkt_if.pkt_valid = vecs[i].valid;
            pkt_if.pkt_type  = vecs[i].ptype;
            pkt_if.pkt_slot  = vecs[i].slot;
            #1;
            check($sformatf("pkt_ready row %0d", i), 32'(pkt_if.pkt_ready),
                  32'(vecs[i].exp_ready));
            if (vecs[i].fwd) sb.push_back('{ptype: vecs[i].ptype, due: cyc + 1});
            @(negedge clk);
            check($sformatf("state row %0d", i), 32'(state), 32'(vecs[i].exp_state));
            check($sformatf("setup_fail row %0d", i), 32'(setup_fail), 32'(vecs[i].exp_fail));
        end
        pkt_if.pkt_valid = 1'b0;
        nrst             = 1'b1;
        step(1);

        // CH_WAIT timeout, then a CH accepted on the final cycle must win over the timeout
        send(T_HB, 16'd0, 1'b1);
        k = 0;
        while (setup_fail !== 1'b1 && k < 2000) begin
            @(negedge clk);
            k++;
        end
        check("CH_WAIT timeout cycles", 32'(k), 32'(TIMEOUT));
        check("state after timeout", 32'(state), 32'(S_IDLE));
        role = 1'b0;
        send(T_HB, 16'd0, 1'b1);
        step(TIMEOUT - 1);
        send(T_CH, 16'd0, 1'b1);
        check("CH beats timeout state", 32'(state), 32'(S_ROLE));
        check("CH beats timeout fail", 32'(setup_fail), 0);

        // Slot 3, low_E clear: third tick grants tx; one full frame stays in TDMA
        to_tdma(1'b0, 16'd3);
        run_ticks(N_SLOTS, 3, 0, -1);

        // Reset mid-TDMA on the tick that would grant tx, with a data packet offered
        to_tdma(1'b0, 16'd3);
        run_ticks(2, 3, 0, -1);
        nrst             = 1'b0;
        slot_tick        = 1'b1;
        pkt_if.pkt_valid = 1'b1;
        pkt_if.pkt_type  = T_DATA;
        #1;
        check("pkt_ready in reset", 32'(pkt_if.pkt_ready), 0);
        @(negedge clk);
        check("reset mid-TDMA pulses",
              32'({en_MNI, tx_req, lowE_skip, round_done, setup_fail}), 0);
        check("reset mid-TDMA fPktType", 32'(fPktType), 32'(T_NONE));
        check("reset mid-TDMA state", 32'(state), 32'(S_IDLE));
        slot_tick        = 1'b0;
        pkt_if.pkt_valid = 1'b0;
        nrst             = 1'b1;

        // Cluster head owns slot 0, reached on the frame wrap; data packet rides a tick
        to_tdma(1'b1, 16'd0);
        run_ticks(N_SLOTS, 0, 0, 7);

        // Full round with low_E during the first frame: skip at slot 3, then round_done
        to_tdma(1'b0, 16'd3);
        run_ticks(N_SLOTS * N_FRAMES, 3, N_SLOTS, 5);

        step(2);
        check("scoreboard drained", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
